seg7_scan_decoder: RTL and testbench

Receive-side monitor for the multiplexed 4-digit 7-segment display interface driven by the counter/display FSM. It watches the active-low anode and segment lines, waits for each digit's pattern to settle, and decodes the segment pattern back to a hex nibble. It assembles the four nibbles into a frame and reports the displayed value with a one-cycle valid strobe. It sits beside the display driver for self-check and for closed-loop verification of the up/down counter.

---
 rtl/seg7_scan_decoder.sv | 197 +++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
// Monitors a multiplexed 4-digit active-low 7-segment interface. It waits for
// each digit pattern to settle, decodes it back to a hex nibble, assembles a
// 4-digit frame and reports it with a one-cycle strobe.
//
// Ports
//   i_clk      system clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   i_an       anode enables, active low (i_an[k]=0 selects digit k)
//   i_seg      segments, active low, {g,f,e,d,c,b,a}
//   o_digits   last complete frame, digit k at [4k+3:4k]
//   o_blank    bit k set if digit k was blank in the last frame
//   o_valid    one-cycle pulse when o_digits/o_blank update
//   o_err      one-cycle pulse on a settled illegal pattern
//   o_stale    no frame completed within TIMEOUT_CYCLES
//
// state    | meaning
// S_WAIT   | pattern changing
// S_SETTLE | pattern repeating, counting towards acceptance
// S_HOLD   | pattern accepted, waiting for it to change
module seg7_scan_decoder #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [3:0]  i_an,
  input  logic [6:0]  i_seg,
  output logic [15:0] o_digits,
  output logic [3:0]  o_blank,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_stale
);

  localparam int          TO_W        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {S_WAIT, S_SETTLE, S_HOLD} state_t;

  logic [3:0]      r_an;
  logic [6:0]      r_seg;
  logic [10:0]     r_prev;
  logic [7:0]      r_cnt;
  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_mask;
  logic [15:0]     r_sh_dig;
  logic [3:0]      r_sh_blk;
  logic            r_err_pend;
  logic [TO_W-1:0] r_to;

  logic       w_same;
  logic [7:0] w_cnt_inc;
  logic       w_accept;
  logic       w_seg_ok;
  logic       w_seg_blank;
  logic [3:0] w_nib;
  logic       w_onecold;
  logic [1:0] w_slot;
  logic       w_idle;
  logic       w_good;
  logic       w_bad;
  logic       w_full;

  assign w_same    = ({r_an, r_seg} == r_prev);
  assign w_cnt_inc = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_idle    = (r_an == 4'hF);
  assign w_full    = (r_mask == 4'hF);

  // Acceptance fires on the transition into HOLD, i.e. on the edge where the
  // stability count reaches SETTLE_CYCLES-1.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    if (!w_same) begin
      w_state_nxt = S_WAIT;
    end else begin
      case (r_state)
        S_WAIT, S_SETTLE: begin
          if (w_cnt_inc == SETTLE_LAST) begin
            w_state_nxt = S_HOLD;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = S_SETTLE;
          end
        end
        S_HOLD:  w_state_nxt = S_HOLD;
        default: w_state_nxt = S_WAIT;
      endcase
    end
  end

  always_comb begin
    w_seg_ok    = 1'b1;
    w_seg_blank = 1'b0;
    w_nib       = 4'h0;
    case (r_seg)
      7'h40: w_nib = 4'h0;
      7'h79: w_nib = 4'h1;
      7'h24: w_nib = 4'h2;
      7'h30: w_nib = 4'h3;
      7'h19: w_nib = 4'h4;
      7'h12: w_nib = 4'h5;
      7'h02: w_nib = 4'h6;
      7'h78: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h10: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h03: w_nib = 4'hB;
      7'h46: w_nib = 4'hC;
      7'h21: w_nib = 4'hD;
      7'h06: w_nib = 4'hE;
      7'h0E: w_nib = 4'hF;
      7'h7F: w_seg_blank = 1'b1;
      default: w_seg_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_onecold = 1'b1;
    w_slot    = 2'd0;
    case (r_an)
      4'b1110: w_slot = 2'd0;
      4'b1101: w_slot = 2'd1;
      4'b1011: w_slot = 2'd2;
      4'b0111: w_slot = 2'd3;
      default: w_onecold = 1'b0;
    endcase
  end

  assign w_good = w_accept && !w_idle && w_onecold && w_seg_ok;
  assign w_bad  = w_accept && !w_idle && !(w_onecold && w_seg_ok);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_prev  <= {4'hF, 7'h7F};
      r_cnt   <= 8'd0;
      r_state <= S_WAIT;
    end else begin
      r_an    <= i_an;
      r_seg   <= i_seg;
      r_prev  <= {r_an, r_seg};
      r_cnt   <= w_same ? w_cnt_inc : 8'd0;
      r_state <= w_state_nxt;
    end
  end

  // An error and a full mask cannot coincide: a full mask lasts one cycle and
  // the next acceptance needs a fresh dwell of at least SETTLE_CYCLES.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask     <= 4'h0;
      r_sh_dig   <= 16'h0;
      r_sh_blk   <= 4'h0;
      r_err_pend <= 1'b0;
      o_err      <= 1'b0;
      o_valid    <= 1'b0;
      o_digits   <= 16'h0;
      o_blank    <= 4'h0;
    end else begin
      r_err_pend <= w_bad;
      o_err      <= r_err_pend;
      o_valid    <= w_full;
      if (w_bad || w_full) begin
        r_mask <= 4'h0;
      end else if (w_good) begin
        r_mask[w_slot] <= 1'b1;
      end
      if (w_good) begin
        r_sh_dig[{w_slot, 2'b00} +: 4] <= w_nib;
        r_sh_blk[w_slot]               <= w_seg_blank;
      end
      if (w_full) begin
        o_digits <= r_sh_dig;
        o_blank  <= r_sh_blk;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_to    <= '0;
      o_stale <= 1'b0;
    end else if (w_full) begin
      r_to    <= '0;
      o_stale <= 1'b0;
    end else if (r_to != TO_MAX) begin
      r_to <= r_to + 1'b1;
      if (r_to == TO_MAX - 1'b1) o_stale <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  i_an;
  logic [6:0]  i_seg;
  logic [15:0] o_digits;
  logic [3:0]  o_blank;
  logic        o_valid;
  logic        o_err;
  logic        o_stale;

  seg7_scan_decoder #(.SETTLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_an     (i_an),
    .i_seg    (i_seg),
    .o_digits (o_digits),
    .o_blank  (o_blank),
    .o_valid  (o_valid),
    .o_err    (o_err),
    .o_stale  (o_stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_valid = 0;
  int   n_err   = 0;
  int   err_long = 0;
  int   last_valid_cyc = 0;
  int   start_cyc = 0;
  int   s3_cyc = 0;
  logic prev_err = 1'b0;
  logic stale_at_valid = 1'b0;

  always @(negedge clk) begin
    if (o_valid) begin
      n_valid++;
      last_valid_cyc = cyc;
      stale_at_valid = o_stale;
    end
    if (o_err) begin
      n_err++;
      if (prev_err) err_long++;
    end
    prev_err = o_err;
  end

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    @(negedge clk);
    i_an  = an;
    i_seg = seg;
    start_cyc = cyc;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic gap();
    hold(4'hF, 7'h7F, 2);
  endtask

  task automatic scan(input logic [6:0] s0, input logic [6:0] s1,
                      input logic [6:0] s2, input logic [6:0] s3);
    hold(4'b1110, s0, 8); gap();
    hold(4'b1101, s1, 8); gap();
    hold(4'b1011, s2, 8); gap();
    hold(4'b0111, s3, 8);
    s3_cyc = start_cyc;
    hold(4'hF, 7'h7F, 6);
  endtask

  task automatic test_reset();
    int v0, e0;
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      i_an  = 4'($urandom);
      i_seg = 7'($urandom);
    end
    n_tests++;
    if ({o_digits, o_blank, o_valid, o_err, o_stale} !== 23'h0) begin
      $display("FAIL reset_outputs: got %h expected 0", {o_digits, o_blank, o_valid, o_err, o_stale});
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_an  = 4'hF;
    i_seg = 7'h7F;
    v0 = n_valid; e0 = n_err;
    repeat (20) @(negedge clk);
    n_tests++;
    if (n_valid != v0 || n_err != e0) begin
      $display("FAIL idle_quiet: got valid=%0d err=%0d expected valid=%0d err=%0d", n_valid, n_err, v0, e0);
      n_fail++;
    end
  endtask

  task automatic test_scan();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    scan(7'h79, 7'h24, 7'h30, 7'h19);
    n_tests++;
    if (n_valid != v0 + 1) begin
      $display("FAIL scan_valid_count: got %0d expected %0d", n_valid - v0, 1);
      n_fail++;
    end
    n_tests++;
    if (o_digits !== 16'h4321 || o_blank !== 4'h0) begin
      $display("FAIL scan_digits: got %h/%b expected 4321/0000", o_digits, o_blank);
      n_fail++;
    end
    n_tests++;
    if (last_valid_cyc != s3_cyc + 6) begin
      $display("FAIL scan_latency: got %0d expected %0d", last_valid_cyc - s3_cyc - 1, 5);
      n_fail++;
    end
    n_tests++;
    if (n_err != e0) begin
      $display("FAIL scan_no_err: got %0d expected %0d", n_err, e0);
      n_fail++;
    end
  endtask

  task automatic test_multi_blank();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    hold(4'b1100, 7'h40, 8); gap(); gap();
    n_tests++;
    if (n_err != e0 + 1 || n_valid != v0) begin
      $display("FAIL multi_anode_err: got err=%0d valid=%0d expected err=%0d valid=%0d", n_err - e0, n_valid - v0, 1, 0);
      n_fail++;
    end
    scan(7'h40, 7'h40, 7'h40, 7'h7F);
    n_tests++;
    if (o_digits !== 16'h0000 || o_blank !== 4'b1000 || n_valid != v0 + 1) begin
      $display("FAIL blank_digit: got %h/%b valid=%0d expected 0000/1000 valid=1", o_digits, o_blank, n_valid - v0);
      n_fail++;
    end
  endtask

  task automatic test_glitch();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    hold(4'b1110, 7'h79, 8); gap();
    hold(4'b1101, 7'h24, 8); gap();
    hold(4'b1011, 7'h00, 3);
    hold(4'b1011, 7'h30, 8); gap();
    hold(4'b0111, 7'h19, 8);
    hold(4'hF, 7'h7F, 6);
    n_tests++;
    if (o_digits !== 16'h4321 || o_blank !== 4'h0 || n_valid != v0 + 1 || n_err != e0) begin
      $display("FAIL glitch_mid: got %h valid=%0d err=%0d expected 4321 valid=1 err=0", o_digits, n_valid - v0, n_err - e0);
      n_fail++;
    end
    v0 = n_valid;
    hold(4'b1110, 7'h12, 8); gap();
    hold(4'b1101, 7'h02, 8); gap();
    hold(4'b1011, 7'h78, 8); gap();
    hold(4'b0111, 7'h00, 3);
    hold(4'hF, 7'h7F, 12);
    n_tests++;
    if (n_valid != v0) begin
      $display("FAIL glitch_last_rejected: got valid=%0d expected 0", n_valid - v0);
      n_fail++;
    end
    hold(4'b0111, 7'h10, 8);
    s3_cyc = start_cyc;
    hold(4'hF, 7'h7F, 6);
    n_tests++;
    if (o_digits !== 16'h9765 || n_valid != v0 + 1 || last_valid_cyc != s3_cyc + 6) begin
      $display("FAIL glitch_then_real: got %h valid=%0d lat=%0d expected 9765 valid=1 lat=5", o_digits, n_valid - v0, last_valid_cyc - s3_cyc - 1);
      n_fail++;
    end
  endtask

  task automatic test_illegal();
    int v0, e0;
    v0 = n_valid; e0 = n_err;
    hold(4'b1110, 7'h40, 8); gap();
    hold(4'b1011, 7'h40, 8); gap();
    hold(4'b0111, 7'h0E, 8); gap();
    hold(4'b1101, 7'h55, 8); gap(); gap();
    n_tests++;
    if (n_err != e0 + 1 || err_long != 0) begin
      $display("FAIL illegal_err_pulse: got pulses=%0d long=%0d expected pulses=1 long=0", n_err - e0, err_long);
      n_fail++;
    end
    hold(4'b1101, 7'h40, 8); gap(); gap();
    n_tests++;
    if (n_valid != v0) begin
      $display("FAIL illegal_mask_cleared: got valid=%0d expected 0", n_valid - v0);
      n_fail++;
    end
    scan(7'h40, 7'h40, 7'h40, 7'h0E);
    n_tests++;
    if (o_digits !== 16'hF000 || o_blank !== 4'h0 || n_valid != v0 + 1) begin
      $display("FAIL illegal_recover: got %h/%b valid=%0d expected F000/0000 valid=1", o_digits, o_blank, n_valid - v0);
      n_fail++;
    end
  endtask

  task automatic test_timeout();
    int v0;
    @(negedge clk);
    rst_n = 1'b0;
    i_an  = 4'hF;
    i_seg = 7'h7F;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (63) @(negedge clk);
    n_tests++;
    if (o_stale !== 1'b0) begin
      $display("FAIL stale_before_64: got %b expected 0", o_stale);
      n_fail++;
    end
    @(negedge clk);
    n_tests++;
    if (o_stale !== 1'b1) begin
      $display("FAIL stale_at_64: got %b expected 1", o_stale);
      n_fail++;
    end
    v0 = n_valid;
    hold(4'b1110, 7'h79, 8); gap();
    hold(4'b1101, 7'h24, 8); gap();
    hold(4'b1011, 7'h30, 8); gap();
    n_tests++;
    if (o_stale !== 1'b1) begin
      $display("FAIL stale_held: got %b expected 1", o_stale);
      n_fail++;
    end
    hold(4'b0111, 7'h19, 8);
    hold(4'hF, 7'h7F, 4);
    n_tests++;
    if (n_valid != v0 + 1 || stale_at_valid !== 1'b0 || o_stale !== 1'b0) begin
      $display("FAIL stale_clears: got valid=%0d stale_at_valid=%b stale=%b expected 1/0/0", n_valid - v0, stale_at_valid, o_stale);
      n_fail++;
    end
  endtask

  task automatic test_reset_midframe();
    int v0;
    hold(4'b1110, 7'h02, 8); gap();
    hold(4'b1101, 7'h02, 8); gap();
    hold(4'b1011, 7'h02, 8); gap();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      i_an  = 4'($urandom);
      i_seg = 7'($urandom);
    end
    n_tests++;
    if ({o_digits, o_blank, o_valid, o_err, o_stale} !== 23'h0) begin
      $display("FAIL reset_mid_outputs: got %h expected 0", {o_digits, o_blank, o_valid, o_err, o_stale});
      n_fail++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    i_an  = 4'hF;
    i_seg = 7'h7F;
    v0 = n_valid;
    gap();
    hold(4'b0111, 7'h19, 8);
    hold(4'hF, 7'h7F, 8);
    n_tests++;
    if (n_valid != v0) begin
      $display("FAIL reset_discards_mask: got valid=%0d expected 0", n_valid - v0);
      n_fail++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_an  = 4'hF;
    i_seg = 7'h7F;
    test_reset();
    test_scan();
    test_multi_blank();
    test_glitch();
    test_illegal();
    test_timeout();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
